// File: rtl/bus_fifo_pkg.sv
// bus_fifo_pkg
//   Shared defaults and helpers for the bus_fifo slice.
//   - BUS_FIFO_WIDTH : default data word width in bits
//   - BUS_FIFO_DEPTH : default entry count (power of two, >= 2)
//   - ptr_width()    : pointer width for a given depth (log2 of depth)
//   - depth_ok()     : true when a depth is a legal power of two >= 2
package bus_fifo_pkg;

  localparam int BUS_FIFO_WIDTH = 8;
  localparam int BUS_FIFO_DEPTH = 4;

  // Pointer width: log2 of the entry count. DEPTH is a power of two,
  // so a pointer of this width wraps from DEPTH-1 to 0 on its own.
  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  // Legal depths are powers of two no smaller than 2.
  function automatic bit depth_ok(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage : bus_fifo_pkg

// File: rtl/bus_fifo_mem.sv
// bus_fifo_mem
//   DEPTH x WIDTH register array used as FIFO storage.
//   One synchronous write port and one asynchronous read port.
//   The array carries no reset: the FIFO never presents an entry it has
//   not written, so stale contents are never observable.
//
// Ports
//   clk    : write clock
//   we     : write enable, array[waddr] <= wdata on the rising edge
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address
//   rdata  : array[raddr], combinational
module bus_fifo_mem
  import bus_fifo_pkg::*;
#(
  parameter int WIDTH = BUS_FIFO_WIDTH,
  parameter int DEPTH = BUS_FIFO_DEPTH,
  parameter int PTR_W = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule : bus_fifo_mem

// File: rtl/bus_fifo.sv
// bus_fifo
//   Synchronous single-clock FIFO with valid/ready handshakes on both
//   sides, an occupancy count and a sticky overflow flag.
//
// Ports
//   clk       : clock, all state changes on its rising edge
//   rstb      : asynchronous active-low reset
//   flush     : synchronous clear of pointers and count (ovf is kept)
//   in_valid  : upstream offers in_data
//   in_ready  : FIFO can accept a word (count != DEPTH)
//   in_data   : write data
//   out_valid : out_data holds the oldest stored word (count != 0)
//   out_ready : downstream takes out_data this cycle
//   out_data  : oldest stored word, zero while empty
//   count     : occupancy 0..DEPTH
//   ovf       : sticky, set when in_valid is seen while full
module bus_fifo
  import bus_fifo_pkg::*;
#(
  parameter int WIDTH = BUS_FIFO_WIDTH,
  parameter int DEPTH = BUS_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rstb,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   ovf
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             ovf_q;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [WIDTH-1:0] rd_word;

  // Handshake flags come only from the registered count, so neither
  // ready nor valid has a combinational path from the opposite side.
  assign full      = (cnt == FULL_CNT);
  assign empty     = (cnt == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;

  // A push while full is impossible (in_ready=0) and a pop while empty is
  // impossible (out_valid=0), so count can never leave 0..DEPTH.
  assign push = in_valid  && in_ready  && !flush;
  assign pop  = out_valid && out_ready && !flush;

  bus_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (in_data),
    .raddr (rd_ptr),
    .rdata (rd_word)
  );

  // The storage array is not reset, so its read word is masked while the
  // FIFO is empty; this keeps out_data at zero during and after reset.
  assign out_data = out_valid ? rd_word : '0;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf_q  <= 1'b0;
    end else begin
      // Overflow looks at the raw request, independent of flush.
      if (in_valid && full) begin
        ovf_q <= 1'b1;
      end

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        // Pointer width equals log2(DEPTH), so +1 wraps DEPTH-1 -> 0.
        if (push) begin
          wr_ptr <= wr_ptr + PTR_ONE;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_ONE;
        end
        unique case ({push, pop})
          2'b10:   cnt <= cnt + CNT_ONE;
          2'b01:   cnt <= cnt - CNT_ONE;
          default: cnt <= cnt;
        endcase
      end
    end
  end

  assign count = cnt;
  assign ovf   = ovf_q;

endmodule : bus_fifo

// File: tb/tb_bus_fifo.sv
module tb_bus_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rstb;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;
  logic             ovf;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Behavioural model: a plain queue of stored words plus the sticky flag.
  logic [WIDTH-1:0] mq[$];
  bit               m_ovf;
  bit               m_push;
  bit               m_pop;

  always #5 clk = ~clk;

  bus_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rstb      (rstb),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .ovf       (ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update: decisions use the state before the edge.
  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      if (in_valid && mq.size() == DEPTH) m_ovf = 1'b1;
      if (flush) begin
        mq.delete();
      end else begin
        m_pop  = (mq.size() != 0) && out_ready;
        m_push = in_valid && (mq.size() != DEPTH);
        if (m_pop)  void'(mq.pop_front());
        if (m_push) mq.push_back(in_data);
      end
    end
  end

  // Compare process: every falling edge while enabled.
  always @(negedge clk) begin
    if (chk_en) begin
      check("count",     32'(count),     32'(mq.size()));
      check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      check("in_ready",  32'(in_ready),  32'(mq.size() != DEPTH));
      check("ovf",       32'(ovf),       32'(m_ovf));
      if (mq.size() != 0) check("out_data", 32'(out_data), 32'(mq[0]));
      else                check("out_data_empty", 32'(out_data), 32'h0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [WIDTH-1:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;

    rstb = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #3;
    check("rst_count",     32'(count),     32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_in_ready",  32'(in_ready),  32'h1);
    check("rst_ovf",       32'(ovf),       32'h0);
    check("rst_out_data",  32'(out_data),  32'h0);
    #9;
    rstb   = 1'b1;
    chk_en = 1'b1;
    tick();

    // Three pushes with downstream stalled.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = vals[i];
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("p3_count",     32'(count),     32'h3);
    check("p3_out_valid", 32'(out_valid), 32'h1);
    check("p3_out_data",  32'(out_data),  32'h11);
    check("p3_in_ready",  32'(in_ready),  32'h1);
    check("p3_ovf",       32'(ovf),       32'h0);

    // Asynchronous reset pulse between edges with three words stored.
    #2 rstb = 1'b0;
    #1;
    check("arst_count",    32'(count),    32'h0);
    check("arst_out_data", 32'(out_data), 32'h0);
    #1 rstb = 1'b1;
    in_valid = 1'b1; in_data = 8'h5A;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("arst_first", 32'(out_data), 32'h5A);
    check("arst_cnt1",  32'(count),    32'h1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Five pushes into a four-deep FIFO, then drain.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 8'hA0 + 8'(i);
      if (i == 4) check("full_in_ready", 32'(in_ready), 32'h0);
      tick();
    end
    in_valid = 1'b0;
    check("full_ovf",   32'(ovf),   32'h1);
    check("full_count", 32'(count), 32'h4);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("drain_data", 32'(out_data), 32'hA0 + 32'(i));
      tick();
    end
    out_ready = 1'b0;
    check("drain_count", 32'(count), 32'h0);

    // Full with both sides active: pop only, then the push lands.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'hB0 + 8'(i);
      tick();
    end
    in_data = 8'hB4; out_ready = 1'b1;
    tick();
    check("fullpop_count", 32'(count),    32'h3);
    check("fullpop_head",  32'(out_data), 32'hB1);
    out_ready = 1'b0;
    tick();
    check("fullpop_refill", 32'(count), 32'h4);
    in_valid = 1'b0;

    // Flush overriding a push at count 2.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 8'hC0 + 8'(i);
      tick();
    end
    check("pre_flush_count", 32'(count), 32'h2);
    flush = 1'b1; in_data = 8'hC2;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_count",     32'(count),     32'h0);
    check("flush_out_valid", 32'(out_valid), 32'h0);
    check("flush_ovf",       32'(ovf),       32'h1);

    // Streaming 0..15 from empty.
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      tick();
      check("stream_count", 32'(count),    32'h1);
      check("stream_data",  32'(out_data), 32'(i));
    end
    in_valid = 1'b0;
    tick();
    check("stream_end", 32'(count), 32'h0);
    out_ready = 1'b0;

    // Randomised traffic with occasional flush and async reset pulses.
    for (int n = 0; n < 3000; n++) begin
      int phase;
      phase     = (n / 250) % 3;
      in_valid  = (phase == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      out_ready = (phase == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
      in_data   = 8'($urandom);
      flush     = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 299) == 0) begin
        #2 rstb = 1'b0;
        #1 rstb = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    tick();
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_bus_fifo

// File: doc/bus_fifo.md
BUS_FIFO -- requirements
Module: bus_fifo

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits.
REQ-002 Parameter DEPTH, default 4: entry count; power of two, at least 2.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rstb  input  1  reset, asynchronous, active-low.
REQ-005 flush  input  1  synchronous clear of all stored entries.
REQ-006 in_valid  input  1  upstream has a word on in_data.
REQ-007 in_ready  output  1  FIFO can accept a word this cycle.
REQ-008 in_data  input  WIDTH  write data.
REQ-009 out_valid  output  1  out_data holds the oldest stored word.
REQ-010 out_ready  input  1  downstream register stage takes out_data this cycle.
REQ-011 out_data  output  WIDTH  oldest stored word.
REQ-012 count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-013 ovf  output  1  sticky flag: push attempted while full.

Function
REQ-014 Push occurs when in_valid && in_ready && !flush; pop occurs when out_valid && out_ready && !flush.
REQ-015 in_ready SHALL equal (count != DEPTH), registered-derived, with no combinational path from out_ready.
REQ-016 out_valid SHALL equal (count != 0); out_data SHALL be the entry at the read pointer, driven from a register or memory read with no in_data-to-out_data bypass.
REQ-017 Latency: a word pushed into an empty FIFO at edge N SHALL appear with out_valid=1 after edge N, visible in cycle N+1.
REQ-018 Ordering SHALL be strict first-in, first-out; no word is dropped or duplicated.
REQ-019 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-020 When full, in_ready=0 even if out_ready=1 in the same cycle; there is no pass-through when full.
REQ-021 When empty, out_valid=0; a same-cycle push is stored but not popped.
REQ-022 Pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH from DEPTH-1 to 0.
REQ-023 count SHALL update as count + push - pop, never exceeding DEPTH or going below 0.
REQ-024 ovf SHALL set at the edge where in_valid=1 while count==DEPTH; it clears only on reset, not on flush.
REQ-025 flush=1 at an edge SHALL zero both pointers and count and override any push or pop in that cycle; storage contents need not be cleared.

Reset
REQ-026 rstb low SHALL immediately force count=0, read and write pointers=0, ovf=0, out_valid=0, and in_ready=1.
REQ-027 out_data SHALL be all zeros during and directly after reset.
REQ-028 Reset asserted mid-transfer SHALL discard all stored words; the first push after rstb rises is the first word popped.
REQ-029 Release of rstb SHALL need no clocking beyond the asynchronous release; the first usable edge is the first rising clk edge after rstb=1.

Structure
REQ-030 Package bus_fifo_pkg SHALL hold the WIDTH and DEPTH defaults and a pointer-width constant or function (log2 of DEPTH).
REQ-031 Storage SHALL be a sub-module bus_fifo_mem: DEPTH x WIDTH register array with one write port and one asynchronous read port, with no reset on the array.
REQ-032 Pointer, count and flag logic SHALL live in bus_fifo; no latches and no additional clocks.

Verification
REQ-033 Reset then push 0x11,0x22,0x33 with out_ready=0 -> count=3, out_valid=1, out_data=0x11, in_ready=1, ovf=0.
REQ-034 Push 5 words 0xA0..0xA4 with DEPTH=4 and out_ready=0 -> 5th not accepted (in_ready=0), ovf=1, count=4; then drain -> 0xA0,0xA1,0xA2,0xA3 in order.
REQ-035 Full FIFO, in_valid=1 and out_ready=1 for one cycle -> pop only, count 4->3, next cycle push accepted, count back to 4.
REQ-036 Continuous streaming of 0..15 with in_valid=out_ready=1 from empty -> steady count=1, output sequence 0..15 with one-cycle latency, pointers wrap without loss.
REQ-037 count=2 and flush=1 with in_valid=1 in the same cycle -> next cycle count=0, out_valid=0, ovf unchanged.
REQ-038 rstb pulsed low between clock edges while count=3 -> count=0 and out_data=0 immediately; next push 0x5A popped first.
